bus_arbiter_mux: RTL and testbench
==================================

# bus_arbiter_mux

Parametrised, registered successor to the datapath bus multiplexer. It drives the shared datapath bus from N source slices. A requesting source is selected by one of two arbitration modes: fixed priority or round-robin with a bounded hold count. The selected data is registered onto the bus, and the grant and encoded select are published alongside it. It sits between the register file, special registers (HI, LO, Z, PC, MDR, In.Port, sign-extended C) and every bus consumer.

## Interface
- WIDTH, 32, bus and per-source data width
- N, 24, number of sources; legal range N ≥ 2
- LOCK_MAX, 4, maximum consecutive cycles one owner holds the bus in round-robin mode while others wait; legal range LOCK_MAX ≥ 1
- SEL_W (localparam), $clog2(N), width of the encoded select
- clock  in  1  single clock, all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- req  in  N  request per source; bit i = source i wants the bus
- data_in  in  N*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH]
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin with hold
- grant  out  N  registered one-hot owner; all-zero when idle
- sel_out  out  SEL_W  registered binary index of the owner; 0 when idle
- bus_valid  out  1  registered; 1 when grant is non-zero
- bus_out  out  WIDTH  registered bus value; 0 when idle

## Operation
- Internal state:
  - owner (SEL_W bits) and owner_valid;
  - last pointer ptr (SEL_W bits), the index of the most recent new grant;
  - hold count cnt, width $clog2(LOCK_MAX+1), saturating at LOCK_MAX.
- Each rising edge computes next owner from req, mode and current state, then loads grant, sel_out, bus_valid and bus_out from that decision in the same edge.
- Idle: req all-zero.
  - grant = 0, bus_valid = 0, sel_out = 0, bus_out = 0, cnt = 0.
  - ptr is unchanged.
- mode 0, fixed priority:
  - Re-arbitrate every cycle; the lowest set index of req wins.
  - cnt is forced to 0; ptr is updated to the winner.
- mode 1, round-robin:
  - Retain the current owner if req[owner] = 1 and (cnt < LOCK_MAX, or no other req bit set).
  - On retain, cnt = min(cnt+1, LOCK_MAX).
  - Otherwise search from (ptr+1) mod N upward with wrap; the first set bit wins, ptr = winner, cnt = 1.
  - The wrap from N-1 to 0 is mandatory.
- An owner dropping req loses the bus at the next edge. The next owner is chosen in that same edge; there is no idle gap if others are requesting.
- A mode change takes effect at the next edge: the decision uses the new mode.
  - Switching to mode 1 with a current owner treats cnt as 0 before the retain check, so that owner is retained with cnt = 1.
- bus_out = data_in slice of the next owner, sampled at the same edge the grant is registered. While ownership is retained, bus_out reloads every cycle, so it tracks source changes with 1-cycle latency.
- Output invariants:
  - grant is always zero or one-hot.
  - sel_out is consistent with grant.
  - bus_valid = |grant.

## Timing
- Latency: req/data at edge k → grant/sel_out/bus_valid/bus_out valid after edge k (one register stage). There is no combinational path from inputs to outputs.
- Reset values (clear = 1 at an edge): grant = 0, sel_out = 0, bus_valid = 0, bus_out = 0, cnt = 0, owner_valid = 0.
  - ptr = N-1, so the first round-robin search begins at index 0.
- clear dominates req and mode at the same edge.
- clear mid-ownership: ownership ends at that edge. The first edge with clear = 0 arbitrates from scratch.
- Round-robin fairness: with K constant requesters, each gets exactly LOCK_MAX consecutive cycles in cyclic index order.
- Simultaneous owner release and new requests: the new owner is picked from the round-robin search at that edge.

## Test plan
- Reset:
  - Stimulus: clear = 1 for 2 cycles with req = all-ones and mode = 1.
  - Required: grant = 0, bus_out = 0, bus_valid = 0 throughout.
  - Then clear = 0: the first grant is source 0 (grant = 0x000001).
- Fixed priority:
  - Stimulus: mode = 0, req = 0x000006, data_in[i] = 0x11111111*i for i < 16.
  - Required: one edge later grant = 0x000002, sel_out = 1, bus_out = 0x11111111.
  - Then req = 0x000004: next edge sel_out = 2, bus_out = 0x22222222.
- Round-robin hold:
  - Stimulus: mode = 1, LOCK_MAX = 4, req bits 2 and 5 held high.
  - Required: sel_out sequence 2,2,2,2,5,5,5,5,2… repeating.
- Saturation:
  - Stimulus: mode = 1, only req[3] high for 10 cycles.
  - Required: sel_out = 3 every cycle.
  - Then req[0] rises: after the next edge sel_out = 0.
- Wrap-around:
  - Stimulus: N = 24, owner 23 at cnt = 4, req bits 0, 22 and 23 set.
  - Required: next grant = source 0, not 22.
- Mid-ownership reset:
  - Stimulus: source 7 owns in mode 1; assert clear for 1 cycle while req[7] stays high, with req[1] also high.
  - Required: outputs zero after the clear edge; the next edge grants source 1.

Source files
------------

// File: rtl/bus_arbiter_mux.sv
// -----------------------------------------------------------------------------
// bus_arbiter_mux
//
// Registered arbiter/multiplexer for the shared datapath bus. N sources request
// the bus; one owner is chosen each cycle by fixed priority (mode 0) or by
// round-robin with a bounded hold count (mode 1). The owner's data slice, a
// one-hot grant, the binary select and a valid flag are all registered in the
// same edge, so there is no combinational path from inputs to outputs.
//
// Ports:
//   clock      in   rising-edge clock
//   clear      in   synchronous active-high reset, dominates every other input
//   req        in   [N-1:0] per-source request
//   data_in    in   [N*WIDTH-1:0] flattened source data, source i at [i*WIDTH +: WIDTH]
//   mode       in   0 = fixed priority (lowest index), 1 = round-robin with hold
//   grant      out  [N-1:0] registered one-hot owner, zero when idle
//   sel_out    out  [SEL_W-1:0] registered binary owner index, zero when idle
//   bus_valid  out  registered, high while grant is non-zero
//   bus_out    out  [WIDTH-1:0] registered owner data, zero when idle
// -----------------------------------------------------------------------------
module bus_arbiter_mux #(
  parameter  int WIDTH    = 32,
  parameter  int N        = 24,
  parameter  int LOCK_MAX = 4,
  localparam int SEL_W    = $clog2(N),
  localparam int CNT_W    = $clog2(LOCK_MAX + 1)
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   data_in,
  input  logic                 mode,
  output logic [N-1:0]         grant,
  output logic [SEL_W-1:0]     sel_out,
  output logic                 bus_valid,
  output logic [WIDTH-1:0]     bus_out
);

  // Arbitration state
  logic [SEL_W-1:0] r_owner;
  logic             r_owner_valid;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  // Registered outputs
  logic [N-1:0]     r_grant;
  logic [WIDTH-1:0] r_bus;

  // Next-state decision
  logic [N-1:0]     w_req_others;
  logic             w_others;
  logic             w_retain;
  logic [SEL_W-1:0] w_fp_idx;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_nxt_owner;
  logic             w_nxt_valid;
  logic [SEL_W-1:0] w_nxt_ptr;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [N-1:0]     w_nxt_grant;
  logic [WIDTH-1:0] w_nxt_data;

  // Fixed priority: lowest set index wins (scan downward so the last hit is the lowest).
  always_comb begin
    w_fp_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) w_fp_idx = SEL_W'(i);
    end
  end

  // Round-robin search starts just after the last new grant and wraps N-1 -> 0.
  // Offset N revisits ptr itself, so a lone requester at ptr is still found.
  always_comb begin
    w_rr_idx   = '0;
    w_rr_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_rr_found && req[idx]) begin
        w_rr_idx   = SEL_W'(idx);
        w_rr_found = 1'b1;
      end
    end
  end

  // The hold limit only matters when someone else is actually waiting.
  always_comb begin
    w_req_others          = req;
    w_req_others[r_owner] = 1'b0;
    w_others              = |w_req_others;
    w_retain              = r_owner_valid && req[r_owner] &&
                            ((r_cnt < CNT_W'(LOCK_MAX)) || !w_others);
  end

  // cnt is held at 0 in fixed-priority mode, so a switch into round-robin
  // retains the current owner and restarts its hold count at 1.
  always_comb begin
    w_nxt_owner = '0;
    w_nxt_valid = 1'b0;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = '0;
    if (|req) begin
      w_nxt_valid = 1'b1;
      if (!mode) begin
        w_nxt_owner = w_fp_idx;
        w_nxt_ptr   = w_fp_idx;
      end else if (w_retain) begin
        w_nxt_owner = r_owner;
        w_nxt_cnt   = (r_cnt < CNT_W'(LOCK_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;
      end else begin
        w_nxt_owner = w_rr_idx;
        w_nxt_ptr   = w_rr_idx;
        w_nxt_cnt   = CNT_W'(1);
      end
    end
  end

  // Output mux: grant decode and data slice of the next owner.
  always_comb begin
    w_nxt_grant = '0;
    w_nxt_data  = '0;
    if (w_nxt_valid) w_nxt_grant[w_nxt_owner] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (w_nxt_valid && (w_nxt_owner == SEL_W'(i)))
        w_nxt_data = data_in[i*WIDTH +: WIDTH];
    end
  end

  // Register stage: decision, grant and bus value all load on the same edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
      r_ptr         <= SEL_W'(N - 1);
      r_cnt         <= '0;
      r_grant       <= '0;
      r_bus         <= '0;
    end else begin
      r_owner       <= w_nxt_owner;
      r_owner_valid <= w_nxt_valid;
      r_ptr         <= w_nxt_ptr;
      r_cnt         <= w_nxt_cnt;
      r_grant       <= w_nxt_grant;
      r_bus         <= w_nxt_data;
    end
  end

  assign grant     = r_grant;
  assign sel_out   = r_owner;
  assign bus_valid = r_owner_valid;
  assign bus_out   = r_bus;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// -----------------------------------------------------------------------------
// Testbench for bus_arbiter_mux: directed scenarios plus a randomized run.
// Every driven cycle pushes the reference expectation onto a scoreboard queue;
// the entry is popped and compared once the DUT has registered that cycle.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_mux;
  localparam int WIDTH    = 32;
  localparam int N        = 24;
  localparam int LOCK_MAX = 4;
  localparam int SEL_W    = $clog2(N);

  logic               clock = 1'b0;
  logic               clear;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] data_in;
  logic               mode;
  logic [N-1:0]       grant;
  logic [SEL_W-1:0]   sel_out;
  logic               bus_valid;
  logic [WIDTH-1:0]   bus_out;

  bus_arbiter_mux #(.WIDTH(WIDTH), .N(N), .LOCK_MAX(LOCK_MAX)) dut (
    .clock    (clock),
    .clear    (clear),
    .req      (req),
    .data_in  (data_in),
    .mode     (mode),
    .grant    (grant),
    .sel_out  (sel_out),
    .bus_valid(bus_valid),
    .bus_out  (bus_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [N-1:0]     g;
    logic [SEL_W-1:0] s;
    logic             v;
    logic [WIDTH-1:0] b;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] d[N];

  // Reference state
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_valid;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_step(input bit clr, input bit md, input logic [N-1:0] rq,
                            output exp_t e);
    bit others;
    int j;
    if (clr) begin
      m_owner = 0; m_valid = 0; m_ptr = N - 1; m_cnt = 0;
    end else if (rq == '0) begin
      m_owner = 0; m_valid = 0; m_cnt = 0;
    end else if (!md) begin
      j = 0;
      while (!rq[j]) j++;
      m_owner = j; m_ptr = j; m_cnt = 0; m_valid = 1;
    end else begin
      others = (rq & ~(N'(1) << m_owner)) != '0;
      if (m_valid && rq[m_owner] && (m_cnt < LOCK_MAX || !others)) begin
        if (m_cnt < LOCK_MAX) m_cnt++;
      end else begin
        j = (m_ptr + 1) % N;
        while (!rq[j]) j = (j + 1) % N;
        m_owner = j; m_ptr = j; m_cnt = 1; m_valid = 1;
      end
    end
    e.g = m_valid ? (N'(1) << m_owner) : '0;
    e.s = SEL_W'(m_owner);
    e.v = m_valid;
    e.b = m_valid ? d[m_owner] : '0;
  endtask

  task automatic cycle(input bit clr, input bit md, input logic [N-1:0] rq);
    exp_t e;
    exp_t p;
    @(negedge clock);
    clear = clr;
    mode  = md;
    req   = rq;
    for (int i = 0; i < N; i++) data_in[i*WIDTH +: WIDTH] = d[i];
    model_step(clr, md, rq, e);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      p = sb_q.pop_front();
      chk("grant",     64'(grant),     64'(p.g));
      chk("sel_out",   64'(sel_out),   64'(p.s));
      chk("bus_valid", 64'(bus_valid), 64'(p.v));
      chk("bus_out",   64'(bus_out),   64'(p.b));
      chk("onehot0",   64'($onehot0(grant)), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int rr_seq[12] = '{2, 2, 2, 2, 5, 5, 5, 5, 2, 2, 2, 2};

  initial begin
    logic [N-1:0] rq;
    bit           clr;
    bit           md;

    clear   = 1'b1;
    mode    = 1'b0;
    req     = '0;
    data_in = '0;
    for (int i = 0; i < N; i++)
      d[i] = (i < 16) ? WIDTH'(32'h11111111 * i) : (32'hA000_0000 | WIDTH'(i));
    m_owner = 0; m_valid = 0; m_ptr = N - 1; m_cnt = 0;

    // Reset with everything requesting in round-robin mode
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, 1'b1, '1);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_bus",   64'(bus_out), 64'd0);
      chk("rst_valid", 64'(bus_valid), 64'd0);
    end
    cycle(1'b0, 1'b1, '1);
    chk("rst_first_grant", 64'(grant), 64'h1);

    // Fixed priority
    cycle(1'b0, 1'b0, 24'h000006);
    chk("fp_grant", 64'(grant), 64'h2);
    chk("fp_sel",   64'(sel_out), 64'd1);
    chk("fp_bus",   64'(bus_out), 64'h11111111);
    cycle(1'b0, 1'b0, 24'h000004);
    chk("fp_sel2",  64'(sel_out), 64'd2);
    chk("fp_bus2",  64'(bus_out), 64'h22222222);

    // Round-robin hold between sources 2 and 5
    cycle(1'b1, 1'b1, '0);
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, 1'b1, 24'h000024);
      chk("rr_seq", 64'(sel_out), 64'(rr_seq[c]));
    end

    // Saturation with a lone requester, then release to a new requester
    cycle(1'b1, 1'b1, '0);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b1, 24'h000008);
      chk("sat_sel", 64'(sel_out), 64'd3);
    end
    cycle(1'b0, 1'b1, 24'h000009);
    chk("sat_release", 64'(sel_out), 64'd0);

    // Wrap-around from owner 23
    cycle(1'b1, 1'b1, '0);
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b1, 24'h800000);
    chk("wrap_owner", 64'(sel_out), 64'd23);
    cycle(1'b0, 1'b1, 24'hC00001);
    chk("wrap_grant", 64'(grant), 64'h1);

    // Mid-ownership reset
    cycle(1'b1, 1'b1, '0);
    cycle(1'b0, 1'b1, 24'h000080);
    cycle(1'b0, 1'b1, 24'h000080);
    chk("mid_owner", 64'(sel_out), 64'd7);
    cycle(1'b1, 1'b1, 24'h000082);
    chk("mid_clr_grant", 64'(grant), 64'd0);
    chk("mid_clr_bus",   64'(bus_out), 64'd0);
    cycle(1'b0, 1'b1, 24'h000082);
    chk("mid_after", 64'(grant), 64'h2);

    // Mode switch: fixed-priority owner retained on entering round-robin
    cycle(1'b0, 1'b0, 24'h000006);
    cycle(1'b0, 1'b1, 24'h000006);
    chk("mode_sw", 64'(sel_out), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 39) == 0);
      md  = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: rq = '0;
        1: rq = N'(1) << $urandom_range(0, N - 1);
        2: rq = N'($urandom) & N'($urandom) & N'($urandom);
        default: rq = N'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) d[$urandom_range(0, N - 1)] = $urandom;
      cycle(clr, md, rq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
